single_port_lutram_access_ctrl: RTL
===================================

Name: single_port_lutram_access_ctrl

Overview:
Request front-end that sits directly upstream of single_port_lutram and is the only agent driving its port. It takes independent write and read request channels (valid/ready) and serialises them onto the single access port with round-robin arbitration. It returns read data through a flow-controlled response channel backed by a small response FIFO, so a stalled consumer never loses data.

Parameters:
SINGLE_ENTRY_SIZE_IN_BITS, 64, entry width in bits
NUM_SET, 64, number of entries in the lutram
SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width
WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS/8, byte write-mask width
READ_LATENCY, 1, edges from the command edge to valid lutram read data (1..2)
RESP_DEPTH, 2, response FIFO depth (power of 2, >= 2)

Ports:
clk_in  input  1  clock, rising edge
reset_in  input  1  asynchronous active-low reset
wr_req_valid_in  input  1  write request valid
wr_req_ready_out  output  1  write request accepted this cycle if valid
wr_req_addr_in  input  SET_PTR_WIDTH_IN_BITS  write set address
wr_req_mask_in  input  WRITE_MASK_LEN  byte write mask
wr_req_data_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data
rd_req_valid_in  input  1  read request valid
rd_req_ready_out  output  1  read request accepted this cycle if valid
rd_req_addr_in  input  SET_PTR_WIDTH_IN_BITS  read set address
rd_resp_valid_out  output  1  response FIFO non-empty
rd_resp_ready_in  input  1  consumer pops a response
rd_resp_data_out  output  SINGLE_ENTRY_SIZE_IN_BITS  head-of-FIFO read data
lutram_access_en_out  output  1  to lutram access_en_in
lutram_write_en_out  output  WRITE_MASK_LEN  to lutram write_en_in
lutram_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  to lutram access_set_addr_in
lutram_write_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  to lutram write_entry_in
lutram_read_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  from lutram read_entry_out

Behaviour:
- Reset (reset_in=0, asynchronous): all outputs 0, response FIFO empty, in-flight count 0, priority pointer = write.
- Credit: credits = RESP_DEPTH - fifo_count - reads_in_flight. A read is in flight from its accept edge until its data is pushed.
- Read eligible iff rd_req_valid_in && credits > 0. Write eligible iff wr_req_valid_in. Writes never need credit.
- Arbitration is combinational:
  - Only one eligible: it is granted.
  - Both eligible: the side named by the priority pointer is granted; the pointer then flips to the other side.
  - The pointer changes only on contended grants.
- wr_req_ready_out = write granted. rd_req_ready_out = read granted. At most one is 1 per cycle. A ready is never asserted without its valid.
- Command register, loaded at the accept edge:
  - access_en = 1.
  - set_addr = granted address.
  - write: write_en = mask, write_entry = data.
  - read: write_en = 0, write_entry holds its previous value.
  - No grant: access_en = 0 and write_en = 0 at that edge; address and data hold.
- A write accepted with an all-zero mask still issues the access cycle and modifies nothing.
- Read return: lutram_read_entry_in is sampled READ_LATENCY edges after the edge on which the command register presented the read, then pushed into the FIFO.
  - Total request-to-response latency is 1 + READ_LATENCY cycles. With READ_LATENCY=1, rd_resp_valid_out rises 2 edges after accept when the FIFO was empty.
- Tracking: a shift register of READ_LATENCY+1 bits marks which pipeline slots carry reads. Writes never push.
- Response FIFO:
  - Circular buffer with wrapping pointers.
  - Head data is shown on rd_resp_data_out; it is valid whenever rd_resp_valid_out=1.
  - A pop and a push in the same cycle both take effect; count is unchanged.
  - The credit rule guarantees no overflow. Overflow is an assertion failure in simulation.
- Ordering: responses return in read-accept order. A read accepted on the cycle after a write to the same address returns the new data, because the port is strictly sequential.
- Same-cycle accept and credit return: credits are computed from registered state only. A pop in the current cycle does not free a credit until the next cycle.
- Reset asserted mid-operation discards in-flight reads and FIFO contents. No response is produced after reset is released.

Test Plan:
- Reset then single write: addr 63, mask 0xFF, data 0xFFFFFFFF_00000000 -> next cycle access_en=1, write_en=0xFF, addr=63; following cycle access_en=0.
- Read back addr 63 with rd_resp_ready_in=1 -> rd_resp_valid_out=1 exactly 2 edges after accept, data 0xFFFFFFFF_00000000, for one cycle.
- Both channels valid for 4 cycles, write to addr 5, read addr 63, consumer ready -> grants alternate W,R,W,R. The read issued after the first write to addr 5 returns data consistent with issue order.
- Consumer stalled (rd_resp_ready_in=0), 4 reads issued back-to-back -> only 2 accepted, then rd_req_ready_out=0. Raising ready pops 2 responses in order, then reads resume.
- Partial mask: write 0x0 to addr 10 with mask 0xFF, then 0xAAAA... with mask 0x0F, then read -> 0x00000000_AAAAAAAA.
- Reset pulse while 1 read is in flight and 1 response is held -> after release, rd_resp_valid_out stays 0 and full credits (2 reads) are available.

Source files
------------

// File: rtl/single_port_lutram_access_ctrl.sv
// rtl/single_port_lutram_access_ctrl.sv - round-robin write/read front-end for a single-port lutram
// Serialises write and read requests onto one access port and returns read data through a credited FIFO.
module single_port_lutram_access_ctrl #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / 8,
  parameter int READ_LATENCY              = 1,
  parameter int RESP_DEPTH                = 2
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 wr_req_valid_in,
  output logic                                 wr_req_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     wr_req_addr_in,
  input  logic [WRITE_MASK_LEN-1:0]            wr_req_mask_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] wr_req_data_in,
  input  logic                                 rd_req_valid_in,
  output logic                                 rd_req_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     rd_req_addr_in,
  output logic                                 rd_resp_valid_out,
  input  logic                                 rd_resp_ready_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rd_resp_data_out,
  output logic                                 lutram_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]            lutram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     lutram_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_read_entry_in
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TRK_W = READ_LATENCY + 1;
  localparam logic [7:0]       DEPTH_OCC = 8'(RESP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RESP_DEPTH);

  logic                                 prio_read_q, prio_read_d;
  logic                                 access_en_q, access_en_d;
  logic [WRITE_MASK_LEN-1:0]            write_en_q, write_en_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     set_addr_q, set_addr_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_q, write_entry_d;
  logic [TRK_W-1:0]                     trk_q, trk_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] fifo_mem_q [RESP_DEPTH];
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] fifo_mem_d [RESP_DEPTH];
  logic [PTR_W-1:0]                     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;

  logic [7:0] inflight, occupied;
  logic       wr_elig, rd_elig, wr_grant, rd_grant, push, pop;

  always_comb begin
    // Credits come only from registered state, so a same-cycle pop cannot admit a read.
    inflight = '0;
    for (int i = 0; i < TRK_W; i++) begin
      inflight = inflight + 8'(trk_q[i]);
    end
    occupied = 8'(cnt_q) + inflight;
    wr_elig  = wr_req_valid_in;
    rd_elig  = rd_req_valid_in && (occupied < DEPTH_OCC);
    wr_grant = wr_elig && (!rd_elig || !prio_read_q);
    rd_grant = rd_elig && !wr_grant;
    prio_read_d = (wr_elig && rd_elig) ? !prio_read_q : prio_read_q;

    access_en_d   = wr_grant || rd_grant;
    write_en_d    = wr_grant ? wr_req_mask_in : '0;
    set_addr_d    = wr_grant ? wr_req_addr_in : (rd_grant ? rd_req_addr_in : set_addr_q);
    write_entry_d = wr_grant ? wr_req_data_in : write_entry_q;

    trk_d = {trk_q[TRK_W-2:0], rd_grant};
    push  = trk_q[TRK_W-1];
    pop   = rd_resp_ready_in && (cnt_q != '0);

    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wptr_q] = lutram_read_entry_in;
    end
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PTR_W'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      prio_read_q   <= 1'b0;
      access_en_q   <= 1'b0;
      write_en_q    <= '0;
      set_addr_q    <= '0;
      write_entry_q <= '0;
      trk_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      prio_read_q   <= prio_read_d;
      access_en_q   <= access_en_d;
      write_en_q    <= write_en_d;
      set_addr_q    <= set_addr_d;
      write_entry_q <= write_entry_d;
      trk_q         <= trk_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      fifo_mem_q    <= fifo_mem_d;
    end
  end

  assign wr_req_ready_out       = wr_grant;
  assign rd_req_ready_out       = rd_grant;
  assign rd_resp_valid_out      = (cnt_q != '0);
  assign rd_resp_data_out       = fifo_mem_q[rptr_q];
  assign lutram_access_en_out   = access_en_q;
  assign lutram_write_en_out    = write_en_q;
  assign lutram_set_addr_out    = set_addr_q;
  assign lutram_write_entry_out = write_entry_q;

  no_fifo_overflow: assert property (@(posedge clk_in) disable iff (!reset_in)
    !(push && !pop && cnt_q == DEPTH_CNT));

endmodule
